prom_burst: RTL

PROM_BURST -- requirements
Module: prom_burst

---
 rtl/prom_pkg.sv | 14 +
 rtl/prom_burst_array.sv | 19 +
 rtl/prom_burst.sv | 81 ++++++++
 3 files changed

// File: rtl/prom_pkg.sv
// Shared types and boot image for the burst-read PROM.
package prom_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, DATA} state_t;

    localparam int BOOT_WORDS = 8;

    // Words 6 and 7 pad the image so a 3-bit index is always in range.
    localparam logic [15:0] BOOT_IMAGE [BOOT_WORDS] = '{
        16'hF000, 16'hF101, 16'hF210, 16'hFA10,
        16'h7020, 16'hE1FE, 16'h0000, 16'h0000
    };

endpackage

// File: rtl/prom_burst_array.sv
// Read-only storage holding the boot image; combinational read port.
module prom_array
    import prom_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    // Only the first BOOT_WORDS locations carry data; the rest read as zero.
    always_comb begin
        rdata = '0;
        if (raddr[ADDR_W-1:3] == '0)
            rdata = DATA_W'(BOOT_IMAGE[raddr[2:0]]);
    end

endmodule

// File: rtl/prom_burst.sv
// Burst-read PROM: fixed access latency, then page-mode words with consumer stall.
module prom_burst
    import prom_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int ACCESS_CYC = 3,
    parameter int LEN_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              oen,
    output logic              ready,
    output logic [DATA_W-1:0] dout,
    output logic              dvalid,
    output logic              last
);

    localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYC - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] cur;
    logic [LEN_W-1:0]  remain;
    logic [DATA_W-1:0] rdata;

    prom_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .raddr (cur),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            cur    <= '0;
            remain <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        cur    <= addr;
                        remain <= (len == '0) ? LEN_W'(1) : len;
                        cnt    <= CNT_INIT;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0)
                        state <= DATA;
                    else
                        cnt <= cnt - 4'd1;
                end
                DATA: begin
                    if (!oen) begin
                        cur    <= cur + ADDR_W'(1);
                        remain <= remain - LEN_W'(1);
                        if (remain == LEN_W'(1))
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stall must blank the word in the same cycle, so the outputs decode registered state and oen.
    always_comb begin
        ready  = (state == IDLE);
        dvalid = (state == DATA) && !oen;
        last   = dvalid && (remain == LEN_W'(1));
        dout   = dvalid ? rdata : '0;
    end

endmodule
